// File: rtl/single_to_int_pkg.sv
// rtl/single_to_int_pkg.sv - constants, pipeline records and unpack helper for single_to_int
// Optional build macro SINGLE_TO_INT_SATURATE_EN selects saturating out-of-range results.
package single_to_int_pkg;

   localparam logic [7:0]  EXP_BIAS    = 8'd127;
   localparam logic [7:0]  EXP_MAX_INT = 8'd158;
   localparam logic [7:0]  EXP_SPECIAL = 8'd255;
   localparam logic [31:0] INT_MIN     = 32'h8000_0000;
   localparam logic [31:0] INT_MAX     = 32'h7FFF_FFFF;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int MANT_MSB = 22;

`ifdef SINGLE_TO_INT_SATURATE_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [23:0] mant;
      logic        is_zero;
      logic        is_small;
      logic        is_big;
      logic        is_nan_inf;
      logic        is_nan;
   } unpack_t;

   typedef struct packed {
      logic        sign;
      logic [31:0] mag;
      logic        zero_out;
      logic        special;
   } conv_t;

   function automatic unpack_t unpack(input logic [31:0] x);
      unpack_t u;
      u.sign       = x[SIGN_BIT];
      u.exp        = x[EXP_MSB:EXP_LSB];
      u.mant       = {1'b1, x[MANT_MSB:0]};
      u.is_zero    = (u.exp == 8'd0);
      u.is_small   = (u.exp < EXP_BIAS);
      u.is_big     = (u.exp >= EXP_MAX_INT);
      u.is_nan_inf = (u.exp == EXP_SPECIAL);
      u.is_nan     = u.is_nan_inf && (x[MANT_MSB:0] != 23'd0);
      return u;
   endfunction

endpackage

// File: rtl/single_to_int_shift.sv
// rtl/single_to_int_shift.sv - combinational 32-bit 5-level logarithmic right barrel shifter
module single_to_int_shift
   import single_to_int_pkg::*;
(
   input  logic [31:0] din,
   input  logic [4:0]  shamt,
   output logic [31:0] dout
);

   logic [31:0] lvl0, lvl1, lvl2, lvl3;

   assign lvl0 = shamt[0] ? (din  >> 1)  : din;
   assign lvl1 = shamt[1] ? (lvl0 >> 2)  : lvl0;
   assign lvl2 = shamt[2] ? (lvl1 >> 4)  : lvl1;
   assign lvl3 = shamt[3] ? (lvl2 >> 8)  : lvl2;
   assign dout = shamt[4] ? (lvl3 >> 16) : lvl3;

endmodule

// File: rtl/single_to_int.sv
// rtl/single_to_int.sv - IEEE-754 single to int32, truncating, 2-cycle pipelined converter
// SINGLE_TO_INT_SATURATE_EN: clamp to INT_MAX/INT_MIN and map NaN to 0 instead of INT_MIN.
module single_to_int
   import single_to_int_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   output logic [31:0] z
);

   unpack_t     s1_d, s1_q;
   conv_t       s2_d, s2_q;
   logic [31:0] z_d, z_q;
   logic [4:0]  shamt;
   logic [31:0] shifted;

   // Only exponents 127..157 reach the shifter result, giving shift amounts 1..31.
   assign shamt = 5'(EXP_MAX_INT - s1_q.exp);

   single_to_int_shift u_shift (
      .din   ({s1_q.mant, 8'b0}),
      .shamt (shamt),
      .dout  (shifted)
   );

   always_comb begin
      s1_d = unpack(a);
   end

   always_comb begin
      s2_d          = '0;
      s2_d.sign     = s1_q.sign;
      s2_d.mag      = shifted;
      s2_d.zero_out = s1_q.is_zero | s1_q.is_small | (SAT_EN & s1_q.is_nan);
      s2_d.special  = s1_q.is_big | s1_q.is_nan_inf;
   end

   always_comb begin
      z_d = '0;
      if (s2_q.zero_out) begin
         z_d = '0;
      end else if (s2_q.special) begin
         z_d = (SAT_EN && !s2_q.sign) ? INT_MAX : INT_MIN;
      end else begin
         z_d = s2_q.sign ? (-s2_q.mag) : s2_q.mag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
         z_q  <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         z_q  <= z_d;
      end
   end

   assign z = z_q;

endmodule

// File: tb/tb_single_to_int.sv
// tb/tb_single_to_int.sv - randomized self-checking bench for single_to_int
// Honours SINGLE_TO_INT_SATURATE_EN for expected out-of-range results.
module tb_single_to_int;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a   = '0;
   logic [31:0] z;

   int total = 0;
   int bad   = 0;

   logic [31:0] pipe_q[$];

   single_to_int dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .z   (z)
   );

   always #5 clk = ~clk;

`ifdef SINGLE_TO_INT_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Real-valued reference: value = mantissa * 2^(exp-150), then a C-style truncating cast.
   function automatic logic [31:0] ref_model(input logic [31:0] x);
      int          e;
      int          p;
      real         v;
      logic [22:0] f;
      e = int'(x[30:23]);
      f = x[22:0];
      if (e == 255) begin
         if (f != 0) return SAT ? 32'h0 : 32'h8000_0000;
         return (SAT && !x[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
      end
      if (e == 0) begin
         v = real'(f);
         p = -149;
      end else begin
         v = real'(f) + 8388608.0;
         p = e - 150;
      end
      if (p > 0) repeat (p) v = v * 2.0;
      else       repeat (-p) v = v * 0.5;
      if (x[31]) v = -v;
      if (v >= 2147483648.0) return SAT ? 32'h7FFF_FFFF : 32'h8000_0000;
      if (v < -2147483648.0) return 32'h8000_0000;
      return 32'($rtoi(v));
   endfunction

   // One clock: drive inputs, advance past the edge, compare z with the modelled pipeline.
   task automatic step(input logic [31:0] val, input logic r, input string tag);
      logic [31:0] exp;
      a   = val;
      rst = r;
      @(posedge clk);
      #1;
      if (r) begin
         pipe_q.delete();
         pipe_q.push_back(32'h0);
         pipe_q.push_back(32'h0);
         exp = 32'h0;
      end else begin
         exp = pipe_q.pop_front();
         pipe_q.push_back(ref_model(val));
      end
      check(tag, z, exp);
   endtask

   typedef struct {
      logic [31:0] op;
      logic [31:0] res;
      string       name;
   } vec_t;

   vec_t vecs[$];

   initial begin
      vecs.push_back('{32'h3F80_0000, 32'h0000_0001, "one"});
      vecs.push_back('{32'h42F6_E666, 32'h0000_007B, "123_45"});
      vecs.push_back('{32'hC020_0000, 32'hFFFF_FFFE, "neg2_5"});
      vecs.push_back('{32'h3F40_0000, 32'h0000_0000, "0_75"});
      vecs.push_back('{32'h8000_0000, 32'h0000_0000, "neg_zero"});
      vecs.push_back('{32'h0000_0001, 32'h0000_0000, "denormal"});
      vecs.push_back('{32'h4EFF_FFFF, 32'h7FFF_FF80, "max_in_range"});
      vecs.push_back('{32'hCF00_0000, 32'h8000_0000, "neg_2p31"});
      vecs.push_back('{32'h4F00_0000, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, "pos_2p31"});
      vecs.push_back('{32'h7FC0_0000, SAT ? 32'h0000_0000 : 32'h8000_0000, "nan"});
      vecs.push_back('{32'h7F80_0000, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, "pos_inf"});
      vecs.push_back('{32'hFF80_0000, 32'h8000_0000, "neg_inf"});

      step(32'h3F80_0000, 1'b1, "reset");
      step(32'h3F80_0000, 1'b1, "reset");
      check("reset_z", z, 32'h0);
      step(32'h3F80_0000, 1'b0, "post_reset_0");
      step(32'h3F80_0000, 1'b0, "post_reset_1");
      step(32'h0,         1'b0, "post_reset_2");
      check("first_result", z, 32'h1);

      // Isolated operands against literal expectations, confirming the 2-edge latency.
      foreach (vecs[i]) begin
         step(vecs[i].op, 1'b0, "dir_in");
         step(32'h0,      1'b0, "dir_gap");
         check({vecs[i].name, "_early"}, z, 32'h0);
         step(32'h0,      1'b0, "dir_out");
         check(vecs[i].name, z, vecs[i].res);
      end

      // Back-to-back directed operands.
      foreach (vecs[i]) step(vecs[i].op, 1'b0, "dir_stream");

      for (int i = 0; i < 10000; i++) begin
         logic [31:0] op;
         op = $urandom;
         if ($urandom_range(0, 1) == 0) op[30:23] = 8'($urandom_range(118, 162));
         step(op, (i == 5000) ? 1'b1 : 1'b0, (i >= 5000 && i <= 5002) ? "mid_reset" : "random");
      end

      step(32'h0, 1'b0, "drain");
      step(32'h0, 1'b0, "drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
